// File: rtl/vga_stream_if.sv
// Pixel stream handshake between a frame source and the VGA output stage.
// Each word carries packed {R,G,B} data plus a start-of-frame flag.
interface vga_stream_if #(
  parameter int COLOR_W = 4
);
  logic                   s_valid;
  logic                   s_ready;
  logic [3*COLOR_W-1:0]   s_data;
  logic                   s_sof;

  modport master (output s_valid, s_data, s_sof, input s_ready);
  modport slave  (input s_valid, s_data, s_sof, output s_ready);
endinterface

// File: rtl/vga_stream_timing.sv
// VGA output stage: raster timing, stream FIFO with SOF-based frame alignment,
// and registered sync/de/position/colour outputs one cycle behind the counters.
module vga_stream_timing #(
  parameter int COLOR_W    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  vga_stream_if.slave                   stream,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          de,
  output logic [$clog2(H_ACTIVE)-1:0]   x,
  output logic [$clog2(V_ACTIVE)-1:0]   y,
  output logic [3*COLOR_W-1:0]          rgb_data,
  output logic                          frame_start,
  output logic                          underflow,
  output logic                          sof_err
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PIX_W   = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic           de_int, hs_int, vs_int, at_origin;
  logic [PIX_W:0] mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full, push, pop;
  logic           head_sof;
  logic [PIX_W-1:0] head_data;
  state_t         state, state_nxt;
  logic           pix_ok, ufl, serr;

  // Stage p0: raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign de_int    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_int    = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs_int    = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty          = (wr_ptr == rd_ptr);
  assign full           = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign stream.s_ready = !full && !rst;
  assign push           = stream.s_valid && stream.s_ready;
  assign head_sof       = mem[rd_ptr[AW-1:0]][PIX_W];
  assign head_data      = mem[rd_ptr[AW-1:0]][PIX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {stream.s_sof, stream.s_data};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pop decisions look at the live counters; the result is registered below.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    pix_ok    = 1'b0;
    ufl       = 1'b0;
    serr      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head_sof) state_nxt = ARMED;
          else          pop       = 1'b1;
        end
      end
      ARMED: begin
        if (at_origin) begin
          state_nxt = RUN;
          pop       = 1'b1;
          pix_ok    = 1'b1;
        end
      end
      RUN: begin
        if (de_int) begin
          if (empty) begin
            ufl       = 1'b1;
            state_nxt = IDLE;
          end else if (at_origin) begin
            if (head_sof) begin
              pop    = 1'b1;
              pix_ok = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else if (head_sof) begin
            serr      = 1'b1;
            state_nxt = ARMED;
          end else begin
            pop    = 1'b1;
            pix_ok = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic             hsync_p1, vsync_p1, vld_p1, fs_p1, ufl_p1, serr_p1;
  logic [XW-1:0]    x_p1;
  logic [YW-1:0]    y_p1;
  logic [PIX_W-1:0] rgb_p1;

  // Stage p1: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_p1 <= !SYNC_POL;
      vsync_p1 <= !SYNC_POL;
      vld_p1   <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      rgb_p1   <= '0;
      fs_p1    <= 1'b0;
      ufl_p1   <= 1'b0;
      serr_p1  <= 1'b0;
    end else begin
      hsync_p1 <= hs_int ? SYNC_POL : !SYNC_POL;
      vsync_p1 <= vs_int ? SYNC_POL : !SYNC_POL;
      vld_p1   <= de_int;
      x_p1     <= de_int ? h_cnt[XW-1:0] : '0;
      y_p1     <= de_int ? v_cnt[YW-1:0] : '0;
      rgb_p1   <= pix_ok ? head_data : '0;
      fs_p1    <= at_origin;
      ufl_p1   <= ufl;
      serr_p1  <= serr;
    end
  end

  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign de          = vld_p1;
  assign x           = x_p1;
  assign y           = y_p1;
  assign rgb_data    = rgb_p1;
  assign frame_start = fs_p1;
  assign underflow   = ufl_p1;
  assign sof_err     = serr_p1;
endmodule

// File: tb/tb_vga_stream_timing.sv
// Bench for vga_stream_timing on a 16x8 raster: timing checkpoints from a table,
// plus per-cycle frame checks for full-frame, underflow, misaligned-SOF and mid-frame reset.
module tb_vga_stream_timing;
  localparam int CW = 4;
  localparam int PW = 3 * CW;

  logic clk = 1'b0;
  logic rst;
  logic hsync, vsync, de, frame_start, underflow, sof_err;
  logic [2:0] x;
  logic [1:0] y;
  logic [PW-1:0] rgb_data;

  vga_stream_if #(.COLOR_W(CW)) stream ();

  vga_stream_timing #(
    .COLOR_W(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .stream(stream),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y), .rgb_data(rgb_data),
    .frame_start(frame_start), .underflow(underflow), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       hs;
    logic       vs;
    logic       de;
    logic [2:0] x;
    logic [1:0] y;
  } tv_t;

  tv_t tv [14];
  int total = 0;
  int bad = 0;
  int oidx;
  int accepted;
  bit saw_stall;
  logic [PW:0] src_q [$];
  localparam logic [22:0] RST_VEC = {1'b1, 1'b1, 21'd0};

  function automatic logic [22:0] act_vec();
    return {hsync, vsync, de, x, y, rgb_data, frame_start, underflow, sof_err};
  endfunction

  // Expected outputs for output index oi (counter value one cycle earlier).
  function automatic logic [22:0] exp_vec(int oi, logic [PW-1:0] pix, logic uf, logic se);
    int c, h, v;
    logic hs, vs, d;
    c  = oi % 128;
    h  = c % 16;
    v  = c / 16;
    d  = (h < 8) && (v < 4);
    hs = !((h >= 10) && (h < 13));
    vs = !((v >= 5) && (v < 7));
    return {hs, vs, d, d ? 3'(h) : 3'd0, d ? 2'(v) : 2'd0, d ? pix : 12'd0, (c == 0), uf, se};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s oidx=%0d got=%h want=%h", name, oidx, act, exp);
    end
  endtask

  task automatic tick();
    bit acc;
    #1;
    stream.s_valid = (src_q.size() > 0);
    if (src_q.size() > 0) begin
      stream.s_sof  = src_q[0][PW];
      stream.s_data = src_q[0][PW-1:0];
    end else begin
      stream.s_sof  = 1'b0;
      stream.s_data = '0;
    end
    if (stream.s_valid && !stream.s_ready) saw_stall = 1'b1;
    acc = stream.s_valid && stream.s_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      src_q.delete(0);
      accepted++;
    end
    oidx++;
  endtask

  // scen: 0 no stream, 1 full frame, 2 underflow, 3 misaligned SOF
  task automatic check_cycle(int scen);
    int f, c, k;
    logic dp, uf, se;
    logic [PW-1:0] pix;
    f   = oidx / 128;
    c   = oidx % 128;
    k   = (c / 16) * 8 + (c % 16);
    dp  = ((c % 16) < 8) && ((c / 16) < 4);
    pix = '0;
    uf  = 1'b0;
    se  = 1'b0;
    if (dp) begin
      case (scen)
        1: if (f == 1) pix = PW'(k);
        2: if (f == 1) begin
             if (k < 10) pix = PW'(k);
             else if (k == 10) uf = 1'b1;
           end
        3: if (f == 1) begin
             if (k < 5) pix = PW'(k);
             else if (k == 5) se = 1'b1;
           end else if (f == 2) begin
             if (k < 27) pix = PW'(k + 5);
             else if (k == 27) uf = 1'b1;
           end
        default: ;
      endcase
    end
    check($sformatf("frame_s%0d", scen), 32'(act_vec()), 32'(exp_vec(oidx, pix, uf, se)));
  endtask

  task automatic run_frames(int scen, int last);
    while (oidx < last) begin
      tick();
      check_cycle(scen);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out", 32'(act_vec()), 32'(RST_VEC));
      check("rst_ready", 32'(stream.s_ready), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(stream.s_ready), 32'd1);
    oidx      = -1;
    accepted  = 0;
    saw_stall = 1'b0;
  endtask

  task automatic load(int n, int sof2);
    for (int j = 0; j < n; j++) src_q.push_back({(j == 0) || (j == sof2), PW'(j)});
  endtask

  initial begin
    tv[0]  = '{0,   1'b1, 1'b1, 1'b1, 3'd0, 2'd0};
    tv[1]  = '{7,   1'b1, 1'b1, 1'b1, 3'd7, 2'd0};
    tv[2]  = '{8,   1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tv[3]  = '{9,   1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tv[4]  = '{10,  1'b0, 1'b1, 1'b0, 3'd0, 2'd0};
    tv[5]  = '{12,  1'b0, 1'b1, 1'b0, 3'd0, 2'd0};
    tv[6]  = '{13,  1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tv[7]  = '{23,  1'b1, 1'b1, 1'b1, 3'd7, 2'd1};
    tv[8]  = '{55,  1'b1, 1'b1, 1'b1, 3'd7, 2'd3};
    tv[9]  = '{64,  1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tv[10] = '{80,  1'b1, 1'b0, 1'b0, 3'd0, 2'd0};
    tv[11] = '{106, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0};
    tv[12] = '{112, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0};
    tv[13] = '{127, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0};

    stream.s_valid = 1'b0;
    stream.s_sof   = 1'b0;
    stream.s_data  = '0;

    // Reset and free-running timing with no stream
    do_reset();
    for (int i = 0; i < 14; i++) begin
      while (oidx < tv[i].idx) begin
        tick();
        check_cycle(0);
      end
      check($sformatf("tv%0d", i), 32'({hsync, vsync, de, x, y}),
            32'({tv[i].hs, tv[i].vs, tv[i].de, tv[i].x, tv[i].y}));
    end

    // Full frame under backpressure
    do_reset();
    load(32, -1);
    run_frames(1, 255);
    check("stall_seen", 32'(saw_stall), 32'd1);

    // Underflow after 10 words, then a black frame in IDLE
    do_reset();
    load(10, -1);
    run_frames(2, 383);

    // SOF on word 5 mid-frame, realigned on the next frame
    do_reset();
    load(32, 5);
    run_frames(3, 383);

    // Reset during line 2, then refill proves the FIFO was cleared
    do_reset();
    load(32, -1);
    run_frames(1, 163);
    rst = 1'b1;
    src_q.delete();
    tick();
    check("mid_rst_out", 32'(act_vec()), 32'(RST_VEC));
    check("mid_rst_ready", 32'(stream.s_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rel_ready", 32'(stream.s_ready), 32'd1);
    oidx     = -1;
    accepted = 0;
    load(6, -1);
    run_frames(0, 127);
    check("refill_count", 32'(accepted), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
